// File: rtl/hilo_bypass_file_pkg.sv
// Shared constants and types for the HI/LO register file and its forwarding network.
package hilo_bypass_file_pkg;

  // Bit positions inside every 2-bit HI/LO mask (write masks, MT selects, busy).
  localparam int HILO_HI_BIT = 1;
  localparam int HILO_LO_BIT = 0;

  // One bit per half: [HILO_HI_BIT] = HI, [HILO_LO_BIT] = LO.
  typedef logic [1:0] hilo_mask_t;

  // Width of a full MULT/DIV result (HI:LO) for a given half width.
  function automatic int dword_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/hilo_bypass_file_fwd_mux.sv
// Priority selector for one HI/LO half across STAGES*LANES writer slots.
// Youngest writer wins: lowest stage first, then highest lane within that stage.
// With no writer the architectural value passes through.
module hilo_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int STAGES = 2
) (
  input  logic [STAGES*LANES-1:0]        wen_i,
  input  logic [STAGES*LANES*DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0]              arch_i,
  output logic [DATA_W-1:0]              data_o
);

  // Walk oldest-to-youngest so the youngest matching slot is the last assignment.
  always_comb begin
    data_o = arch_i;
    for (int s = STAGES - 1; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) begin
        if (wen_i[s*LANES+l]) begin
          data_o = data_i[(s*LANES+l)*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/hilo_bypass_file.sv
// Architectural HI/LO pair with forwarding for the dual-issue pipeline and a
// busy scoreboard for the multiply/divide unit.
//
// Handshake: there is no valid/ready pair here. A read lane's rd_data is usable
// in the same cycle exactly when its rd_stall is low; while rd_stall is high the
// selected half is still owned by the MD unit and rd_data is meaningless.
module hilo_bypass_file
  import hilo_bypass_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int STAGES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [STAGES*LANES*2-1:0]            st_whilo,
  input  logic [STAGES*LANES*2-1:0]            st_is_mt,
  input  logic [STAGES*LANES*2*DATA_W-1:0]     st_hilo,
  input  logic [STAGES*LANES*DATA_W-1:0]       st_mt,
  input  logic [LANES-1:0]                     rd_sel,
  output logic [LANES*DATA_W-1:0]              rd_data,
  output logic [LANES-1:0]                     rd_stall,
  input  logic                                 md_issue,
  input  logic [1:0]                           md_mask,
  input  logic                                 md_done,
  input  logic                                 flush,
  output logic [DATA_W-1:0]                    hi_q,
  output logic [DATA_W-1:0]                    lo_q
);

  localparam int SLOTS = STAGES * LANES;
  localparam int DW2   = dword_w(DATA_W);
  localparam int WB    = STAGES - 1;

  logic [SLOTS-1:0]        hi_wen;
  logic [SLOTS-1:0]        lo_wen;
  logic [SLOTS*DATA_W-1:0] hi_slot;
  logic [SLOTS*DATA_W-1:0] lo_slot;
  logic [DATA_W-1:0]       hi_d;
  logic [DATA_W-1:0]       lo_d;
  hilo_mask_t              busy_q;
  hilo_mask_t              busy_d;

  // Per-slot half value: MTHI/MTLO operand or the matching half of the MD result.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign hi_wen[i] = st_whilo[2*i+HILO_HI_BIT];
    assign lo_wen[i] = st_whilo[2*i+HILO_LO_BIT];
    assign hi_slot[i*DATA_W +: DATA_W] = st_is_mt[2*i+HILO_HI_BIT]
                                         ? st_mt[i*DATA_W +: DATA_W]
                                         : st_hilo[i*DW2+DATA_W +: DATA_W];
    assign lo_slot[i*DATA_W +: DATA_W] = st_is_mt[2*i+HILO_LO_BIT]
                                         ? st_mt[i*DATA_W +: DATA_W]
                                         : st_hilo[i*DW2 +: DATA_W];
  end

  // Read lanes: forward both halves, then pick the requested one.
  for (genvar r = 0; r < LANES; r++) begin : g_rd
    logic [DATA_W-1:0] hi_fwd;
    logic [DATA_W-1:0] lo_fwd;

    hilo_fwd_mux #(.DATA_W(DATA_W), .LANES(LANES), .STAGES(STAGES)) u_hi (
      .wen_i (hi_wen),
      .data_i(hi_slot),
      .arch_i(hi_q),
      .data_o(hi_fwd)
    );

    hilo_fwd_mux #(.DATA_W(DATA_W), .LANES(LANES), .STAGES(STAGES)) u_lo (
      .wen_i (lo_wen),
      .data_i(lo_slot),
      .arch_i(lo_q),
      .data_o(lo_fwd)
    );

    assign rd_data[r*DATA_W +: DATA_W] = rd_sel[r] ? hi_fwd : lo_fwd;
    assign rd_stall[r] = rd_sel[r] ? busy_q[HILO_HI_BIT] : busy_q[HILO_LO_BIT];
  end

  // Commit selection reuses the forwarding mux on the WB stage only, so the
  // highest lane writing a half wins and the register holds when nobody writes.
  hilo_fwd_mux #(.DATA_W(DATA_W), .LANES(LANES), .STAGES(1)) u_commit_hi (
    .wen_i (hi_wen[WB*LANES +: LANES]),
    .data_i(hi_slot[WB*LANES*DATA_W +: LANES*DATA_W]),
    .arch_i(hi_q),
    .data_o(hi_d)
  );

  hilo_fwd_mux #(.DATA_W(DATA_W), .LANES(LANES), .STAGES(1)) u_commit_lo (
    .wen_i (lo_wen[WB*LANES +: LANES]),
    .data_i(lo_slot[WB*LANES*DATA_W +: LANES*DATA_W]),
    .arch_i(lo_q),
    .data_o(lo_d)
  );

  // Scoreboard next state: flush beats everything, a new issue beats a completion.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else if (md_issue && md_done) begin
      busy_d = md_mask;
    end else if (md_issue) begin
      busy_d = busy_q | md_mask;
    end else if (md_done) begin
      busy_d = '0;
    end
  end

  // Architectural HI/LO and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_hilo_bypass_file.sv
// Directed bench for hilo_bypass_file: the driver applies a vector and queues the
// values the DUT must show that cycle; the monitor compares on the falling edge.
module tb_hilo_bypass_file;

  localparam int DATA_W = 32;
  localparam int LANES  = 2;
  localparam int STAGES = 2;
  localparam int SLOTS  = STAGES * LANES;

  localparam int K_RD0   = 0;
  localparam int K_RD1   = 1;
  localparam int K_STALL = 2;
  localparam int K_HI    = 3;
  localparam int K_LO    = 4;

  logic                              clk;
  logic                              rst;
  logic [SLOTS*2-1:0]                st_whilo;
  logic [SLOTS*2-1:0]                st_is_mt;
  logic [SLOTS*2*DATA_W-1:0]         st_hilo;
  logic [SLOTS*DATA_W-1:0]           st_mt;
  logic [LANES-1:0]                  rd_sel;
  logic [LANES*DATA_W-1:0]           rd_data;
  logic [LANES-1:0]                  rd_stall;
  logic                              md_issue;
  logic [1:0]                        md_mask;
  logic                              md_done;
  logic                              flush;
  logic [DATA_W-1:0]                 hi_q;
  logic [DATA_W-1:0]                 lo_q;

  logic [DATA_W-1:0] exp_q[$];
  int                kind_q[$];
  string             name_q[$];
  int                checks;
  int                errors;

  hilo_bypass_file #(.DATA_W(DATA_W), .LANES(LANES), .STAGES(STAGES)) dut (
    .clk     (clk),
    .rst     (rst),
    .st_whilo(st_whilo),
    .st_is_mt(st_is_mt),
    .st_hilo (st_hilo),
    .st_mt   (st_mt),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .rd_stall(rd_stall),
    .md_issue(md_issue),
    .md_mask (md_mask),
    .md_done (md_done),
    .flush   (flush),
    .hi_q    (hi_q),
    .lo_q    (lo_q)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    st_whilo = '0;
    st_is_mt = '0;
    st_hilo  = '0;
    st_mt    = '0;
    rd_sel   = '0;
    md_issue = 1'b0;
    md_mask  = 2'b00;
    md_done  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic set_slot(input int s, input int l, input logic [1:0] whilo,
                          input logic [1:0] is_mt, input logic [2*DATA_W-1:0] hilo,
                          input logic [DATA_W-1:0] mt);
    int i;
    i = s * LANES + l;
    st_whilo[i*2 +: 2]              = whilo;
    st_is_mt[i*2 +: 2]              = is_mt;
    st_hilo[i*2*DATA_W +: 2*DATA_W] = hilo;
    st_mt[i*DATA_W +: DATA_W]       = mt;
  endtask

  task automatic expect_now(input int kind, input logic [DATA_W-1:0] val, input string name);
    kind_q.push_back(kind);
    exp_q.push_back(val);
    name_q.push_back(name);
  endtask

  // Scoreboard monitor: consumes everything queued for this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      int                k;
      logic [DATA_W-1:0] e;
      logic [DATA_W-1:0] a;
      string             n;
      k = kind_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (k)
        K_RD0:   a = rd_data[0 +: DATA_W];
        K_RD1:   a = rd_data[DATA_W +: DATA_W];
        K_STALL: a = {{(DATA_W-LANES){1'b0}}, rd_stall};
        K_HI:    a = hi_q;
        default: a = lo_q;
      endcase
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", n, a, e);
      end
    end
  end

  // Directed stimulus
  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Idle after reset
    rd_sel = 2'b10;
    expect_now(K_HI, 32'h0, "reset_hi");
    expect_now(K_LO, 32'h0, "reset_lo");
    expect_now(K_RD0, 32'h0, "reset_rd0");
    expect_now(K_RD1, 32'h0, "reset_rd1");
    expect_now(K_STALL, 32'h0, "reset_stall");
    step();

    // WB commit lane order: lane 1 MTHI beats lane 0 on HI, lane 0 keeps LO
    clear_inputs();
    set_slot(1, 0, 2'b11, 2'b00, 64'hAAAA_0000_BBBB_0000, 32'h0);
    set_slot(1, 1, 2'b10, 2'b10, 64'h0, 32'h0000_000C);
    rd_sel = 2'b01;
    expect_now(K_RD0, 32'h0000_000C, "wb_fwd_hi");
    expect_now(K_RD1, 32'hBBBB_0000, "wb_fwd_lo");
    expect_now(K_HI, 32'h0, "wb_hi_before");
    step();
    clear_inputs();
    rd_sel = 2'b01;
    expect_now(K_HI, 32'h0000_000C, "commit_hi");
    expect_now(K_LO, 32'hBBBB_0000, "commit_lo");
    expect_now(K_RD0, 32'h0000_000C, "arch_rd_hi");
    expect_now(K_RD1, 32'hBBBB_0000, "arch_rd_lo");
    step();

    // Stage priority on LO: MEM lane 0 MTLO over WB lane 1
    clear_inputs();
    set_slot(0, 0, 2'b01, 2'b01, 64'h0, 32'h0000_1111);
    set_slot(1, 1, 2'b01, 2'b00, 64'h0000_0000_0000_2222, 32'h0);
    expect_now(K_RD0, 32'h0000_1111, "prio_mem");
    expect_now(K_RD1, 32'h0000_1111, "prio_mem_l1");
    step();
    clear_inputs();
    set_slot(1, 1, 2'b01, 2'b00, 64'h0000_0000_0000_2222, 32'h0);
    expect_now(K_RD0, 32'h0000_2222, "prio_wb");
    step();
    clear_inputs();
    expect_now(K_RD0, 32'h0000_2222, "prio_arch");
    expect_now(K_LO, 32'h0000_2222, "prio_lo_q");
    step();

    // Read during a commit of the same half sees the stage value, not the register
    clear_inputs();
    set_slot(1, 0, 2'b01, 2'b00, 64'h0000_0000_0000_3333, 32'h0);
    expect_now(K_RD0, 32'h0000_3333, "commit_bypass");
    expect_now(K_LO, 32'h0000_2222, "commit_bypass_old");
    step();
    clear_inputs();
    expect_now(K_LO, 32'h0000_3333, "commit_bypass_new");
    step();

    // Split halves in MEM: lane 1 MTHI, lane 0 LO from MD result
    clear_inputs();
    set_slot(0, 1, 2'b10, 2'b10, 64'h0, 32'h5555_5555);
    set_slot(0, 0, 2'b01, 2'b00, 64'h9999_9999_6666_6666, 32'h0);
    rd_sel = 2'b01;
    expect_now(K_RD0, 32'h5555_5555, "split_hi");
    expect_now(K_RD1, 32'h6666_6666, "split_lo");
    step();
    clear_inputs();
    expect_now(K_HI, 32'h0000_000C, "split_no_commit_hi");
    expect_now(K_LO, 32'h0000_3333, "split_no_commit_lo");
    step();

    // Scoreboard: issue 11, stall appears the next cycle
    clear_inputs();
    md_issue = 1'b1;
    md_mask  = 2'b11;
    rd_sel   = 2'b10;
    expect_now(K_STALL, 32'h0, "sb_issue_latency");
    step();
    clear_inputs();
    rd_sel = 2'b10;
    expect_now(K_STALL, 32'h3, "sb_busy11");
    md_issue = 1'b1;
    md_done  = 1'b1;
    md_mask  = 2'b01;
    step();
    clear_inputs();
    rd_sel = 2'b10;
    expect_now(K_STALL, 32'h1, "sb_issue_done01");
    flush    = 1'b1;
    md_issue = 1'b1;
    md_mask  = 2'b10;
    step();
    clear_inputs();
    rd_sel = 2'b10;
    expect_now(K_STALL, 32'h0, "sb_flush");
    md_issue = 1'b1;
    md_mask  = 2'b10;
    step();
    clear_inputs();
    rd_sel = 2'b10;
    expect_now(K_STALL, 32'h2, "sb_busy10");
    md_done = 1'b1;
    step();
    clear_inputs();
    rd_sel = 2'b10;
    expect_now(K_STALL, 32'h0, "sb_done");
    step();

    // Reset while busy = 11, then a stray md_done
    clear_inputs();
    md_issue = 1'b1;
    md_mask  = 2'b11;
    step();
    clear_inputs();
    rd_sel = 2'b10;
    expect_now(K_STALL, 32'h3, "rst_busy_before");
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_sel = 2'b10;
    expect_now(K_STALL, 32'h0, "rst_busy_cleared");
    expect_now(K_HI, 32'h0, "rst_hi");
    expect_now(K_LO, 32'h0, "rst_lo");
    md_done = 1'b1;
    step();
    clear_inputs();
    rd_sel = 2'b10;
    expect_now(K_STALL, 32'h0, "stray_done_stall");
    expect_now(K_HI, 32'h0, "stray_done_hi");
    expect_now(K_LO, 32'h0, "stray_done_lo");
    step();

    // Every queued expectation must have been consumed
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
